// File: rtl/branch_stall_ctrl.sv
// Branch stall controller: freezes the PC and squashes IF/ID while a branch
// detected in ID waits for EX to resolve it, then redirects (taken) or
// resumes fetch (not taken). Also keeps sticky protocol error flags and a
// saturating stall-cycle counter.
module branch_stall_ctrl #(
    parameter int unsigned WIDTH_DATA_LENGTH = 32,
    parameter int unsigned MAX_WAIT          = 8,
    parameter int unsigned CNT_WIDTH         = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         Br_Detected,
    input  logic                         Br_Resolved,
    input  logic                         Br_Taken,
    input  logic [WIDTH_DATA_LENGTH-1:0] Br_Target,
    output logic                         PC_Stall,
    output logic                         IF_ID_Bubble,
    output logic                         PC_Sel,
    output logic [WIDTH_DATA_LENGTH-1:0] PC_Target,
    output logic                         Timeout,
    output logic                         Spurious,
    output logic [CNT_WIDTH-1:0]         Stall_Cycles
);

    localparam int unsigned WCW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT     = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t         state;
    logic [WCW-1:0] wait_cnt;

    // Control FSM; the stall/bubble/select outputs are registered together
    // with the state so they always equal a decode of the current state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            PC_Target    <= '0;
            Timeout      <= 1'b0;
            Spurious     <= 1'b0;
            PC_Stall     <= 1'b0;
            IF_ID_Bubble <= 1'b0;
            PC_Sel       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Br_Resolved) begin
                        Spurious <= 1'b1;
                    end
                    if (Br_Detected) begin
                        state        <= WAIT;
                        wait_cnt     <= '0;
                        PC_Stall     <= 1'b1;
                        IF_ID_Bubble <= 1'b1;
                        PC_Sel       <= 1'b0;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (Br_Resolved) begin
                        if (Br_Taken) begin
                            state        <= REDIRECT;
                            PC_Target    <= Br_Target;
                            PC_Stall     <= 1'b0;
                            IF_ID_Bubble <= 1'b1;
                            PC_Sel       <= 1'b1;
                        end else begin
                            state        <= IDLE;
                            PC_Stall     <= 1'b0;
                            IF_ID_Bubble <= 1'b0;
                            PC_Sel       <= 1'b0;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        state        <= IDLE;
                        Timeout      <= 1'b1;
                        PC_Stall     <= 1'b0;
                        IF_ID_Bubble <= 1'b0;
                        PC_Sel       <= 1'b0;
                    end
                end
                REDIRECT: begin
                    if (Br_Resolved) begin
                        Spurious <= 1'b1;
                    end
                    state        <= IDLE;
                    PC_Stall     <= 1'b0;
                    IF_ID_Bubble <= 1'b0;
                    PC_Sel       <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    PC_Stall     <= 1'b0;
                    IF_ID_Bubble <= 1'b0;
                    PC_Sel       <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of cycles spent stalled in WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            Stall_Cycles <= '0;
        end else if (state == WAIT && Stall_Cycles != '1) begin
            Stall_Cycles <= Stall_Cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_stall_ctrl.sv
// Directed bench for branch_stall_ctrl: a default instance plus a
// CNT_WIDTH=4 instance on the same stimulus for counter saturation.
module tb_branch_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        Br_Detected;
    logic        Br_Resolved;
    logic        Br_Taken;
    logic [31:0] Br_Target;

    logic        PC_Stall, IF_ID_Bubble, PC_Sel, Timeout, Spurious;
    logic [31:0] PC_Target;
    logic [15:0] Stall_Cycles;

    logic        s_PC_Stall, s_IF_ID_Bubble, s_PC_Sel, s_Timeout, s_Spurious;
    logic [31:0] s_PC_Target;
    logic [3:0]  s_Stall_Cycles;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    branch_stall_ctrl #(
        .WIDTH_DATA_LENGTH(32),
        .MAX_WAIT(8),
        .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst),
        .Br_Detected(Br_Detected), .Br_Resolved(Br_Resolved),
        .Br_Taken(Br_Taken), .Br_Target(Br_Target),
        .PC_Stall(PC_Stall), .IF_ID_Bubble(IF_ID_Bubble), .PC_Sel(PC_Sel),
        .PC_Target(PC_Target), .Timeout(Timeout), .Spurious(Spurious),
        .Stall_Cycles(Stall_Cycles)
    );

    branch_stall_ctrl #(
        .WIDTH_DATA_LENGTH(32),
        .MAX_WAIT(8),
        .CNT_WIDTH(4)
    ) dut_small (
        .clk(clk), .rst(rst),
        .Br_Detected(Br_Detected), .Br_Resolved(Br_Resolved),
        .Br_Taken(Br_Taken), .Br_Target(Br_Target),
        .PC_Stall(s_PC_Stall), .IF_ID_Bubble(s_IF_ID_Bubble), .PC_Sel(s_PC_Sel),
        .PC_Target(s_PC_Target), .Timeout(s_Timeout), .Spurious(s_Spurious),
        .Stall_Cycles(s_Stall_Cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ctl(input string tag, input logic stall, input logic bub, input logic sel);
        check({tag, ".PC_Stall"}, 64'(PC_Stall), 64'(stall));
        check({tag, ".IF_ID_Bubble"}, 64'(IF_ID_Bubble), 64'(bub));
        check({tag, ".PC_Sel"}, 64'(PC_Sel), 64'(sel));
    endtask

    // Detect a branch and never resolve it: 8 WAIT cycles, then IDLE.
    task automatic run_timeout();
        Br_Detected = 1'b1;
        step();
        Br_Detected = 1'b0;
        repeat (8) step();
    endtask

    initial begin
        rst = 1'b1; Br_Detected = 1'b1; Br_Resolved = 1'b0;
        Br_Taken = 1'b0; Br_Target = '0;

        // 1: reset, detection during reset ignored
        step(); step();
        check_ctl("rst", 1'b0, 1'b0, 1'b0);
        check("rst.PC_Target", 64'(PC_Target), 64'h0);
        check("rst.Timeout", 64'(Timeout), 64'h0);
        check("rst.Spurious", 64'(Spurious), 64'h0);
        check("rst.Stall_Cycles", 64'(Stall_Cycles), 64'h0);
        rst = 1'b0; Br_Detected = 1'b0;
        step();
        check_ctl("post_rst", 1'b0, 1'b0, 1'b0);

        // 2: taken branch resolved in the second WAIT cycle
        Br_Detected = 1'b1;
        step();
        check_ctl("t2.c1", 1'b1, 1'b1, 1'b0);
        Br_Detected = 1'b0;
        step();
        check_ctl("t2.c2", 1'b1, 1'b1, 1'b0);
        Br_Resolved = 1'b1; Br_Taken = 1'b1; Br_Target = 32'h0000_0100;
        step();
        check_ctl("t2.c3", 1'b0, 1'b1, 1'b1);
        check("t2.PC_Target", 64'(PC_Target), 64'h100);
        Br_Resolved = 1'b0; Br_Taken = 1'b0; Br_Target = '0;
        step();
        check_ctl("t2.c4", 1'b0, 1'b0, 1'b0);
        check("t2.Stall_Cycles", 64'(Stall_Cycles), 64'd2);
        check("t2.small_Stall", 64'(s_Stall_Cycles), 64'd2);

        // 3: not-taken branch resolved in the first WAIT cycle
        Br_Detected = 1'b1;
        step();
        check_ctl("t3.c1", 1'b1, 1'b1, 1'b0);
        Br_Detected = 1'b0; Br_Resolved = 1'b1; Br_Taken = 1'b0;
        step();
        check_ctl("t3.c2", 1'b0, 1'b0, 1'b0);
        check("t3.Stall_Cycles", 64'(Stall_Cycles), 64'd3);
        check("t3.PC_Target_kept", 64'(PC_Target), 64'h100);
        check("t3.Spurious", 64'(Spurious), 64'h0);
        Br_Resolved = 1'b0;

        // 4a: timeout after exactly 8 WAIT cycles, sticky
        Br_Detected = 1'b1;
        step();
        Br_Detected = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t4.wait%0d", i), 64'(PC_Stall), 64'h1);
            check($sformatf("t4.to_early%0d", i), 64'(Timeout), 64'h0);
            if (i < 7) step();
        end
        step();
        check_ctl("t4.idle", 1'b0, 1'b0, 1'b0);
        check("t4.Timeout", 64'(Timeout), 64'h1);
        check("t4.Stall_Cycles", 64'(Stall_Cycles), 64'd11);
        step();
        check("t4.Timeout_sticky", 64'(Timeout), 64'h1);

        // 4b: resolve on the 8th WAIT cycle wins over timeout
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t4b.rst_Timeout", 64'(Timeout), 64'h0);
        Br_Detected = 1'b1;
        step();
        Br_Detected = 1'b0;
        repeat (7) step();
        check("t4b.wait8", 64'(PC_Stall), 64'h1);
        Br_Resolved = 1'b1; Br_Taken = 1'b1; Br_Target = 32'h0000_0200;
        step();
        check_ctl("t4b.redir", 1'b0, 1'b1, 1'b1);
        check("t4b.PC_Target", 64'(PC_Target), 64'h200);
        check("t4b.Timeout", 64'(Timeout), 64'h0);
        Br_Resolved = 1'b0; Br_Taken = 1'b0;
        step();
        check_ctl("t4b.idle", 1'b0, 1'b0, 1'b0);
        check("t4b.Stall_Cycles", 64'(Stall_Cycles), 64'd8);

        // 5: spurious resolve in IDLE; detection in REDIRECT ignored
        Br_Resolved = 1'b1;
        step();
        Br_Resolved = 1'b0;
        check("t5.Spurious", 64'(Spurious), 64'h1);
        check_ctl("t5.idle", 1'b0, 1'b0, 1'b0);
        Br_Detected = 1'b1;
        step();
        Br_Detected = 1'b0; Br_Resolved = 1'b1; Br_Taken = 1'b1; Br_Target = 32'h0000_0300;
        step();
        check_ctl("t5.redir", 1'b0, 1'b1, 1'b1);
        Br_Resolved = 1'b0; Br_Taken = 1'b0; Br_Detected = 1'b1;
        step();
        check_ctl("t5.redir_det_ignored", 1'b0, 1'b0, 1'b0);
        step();
        check_ctl("t5.det_after", 1'b1, 1'b1, 1'b0);
        Br_Detected = 1'b0; Br_Resolved = 1'b1; Br_Taken = 1'b0;
        step();
        Br_Resolved = 1'b0;
        check_ctl("t5.back_idle", 1'b0, 1'b0, 1'b0);
        check("t5.Spurious_sticky", 64'(Spurious), 64'h1);
        check("t5.Stall_Cycles", 64'(Stall_Cycles), 64'd10);

        // 6: reset aborts a pending redirect
        Br_Detected = 1'b1;
        step();
        Br_Detected = 1'b0;
        Br_Resolved = 1'b1; Br_Taken = 1'b1; Br_Target = 32'h0000_0400; rst = 1'b1;
        step();
        check_ctl("t6.rst", 1'b0, 1'b0, 1'b0);
        check("t6.PC_Target", 64'(PC_Target), 64'h0);
        check("t6.Spurious", 64'(Spurious), 64'h0);
        rst = 1'b0; Br_Resolved = 1'b0; Br_Taken = 1'b0;
        step();
        check_ctl("t6.idle", 1'b0, 1'b0, 1'b0);

        // 6b: saturation of the 4-bit counter over long stalls
        run_timeout();
        check("t6b.Stall8", 64'(Stall_Cycles), 64'd8);
        check("t6b.small8", 64'(s_Stall_Cycles), 64'd8);
        run_timeout();
        check("t6b.Stall16", 64'(Stall_Cycles), 64'd16);
        check("t6b.small_sat", 64'(s_Stall_Cycles), 64'hF);
        run_timeout();
        check("t6b.Stall24", 64'(Stall_Cycles), 64'd24);
        check("t6b.small_hold", 64'(s_Stall_Cycles), 64'hF);
        check("t6b.small_Timeout", 64'(s_Timeout), 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
